dsi_lane_rx: RTL



---
 rtl/dsi_rx_pkg.sv | 23 ++
 rtl/dsi_lp_sync.sv | 24 ++
 rtl/dsi_lane_rx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/dsi_rx_pkg.sv
// Shared types and constants for the DSI D-PHY data lane receiver.
// Holds the lane FSM state encoding, the LP line-pair codes and the default HS sync byte.
package dsi_rx_pkg;

  typedef enum logic [2:0] {
    DISABLED,
    STOP,
    HS_RQST,
    HS_PREP,
    HS_SYNC,
    HS_DATA,
    ERROR
  } rx_state_e;

  // LP pair codes as {p, n}
  localparam logic [1:0] LP_11 = 2'b11;
  localparam logic [1:0] LP_01 = 2'b01;
  localparam logic [1:0] LP_00 = 2'b00;
  localparam logic [1:0] LP_10 = 2'b10;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hB8;

endpackage

// File: rtl/dsi_lp_sync.sv
// Two-flop synchronizer for the asynchronous LP receiver pair.
// Resets to LP-11 so the lane FSM sees an idle (stop) line out of reset.
module dsi_lp_sync (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       lp_p,
  input  logic       lp_n,
  output logic [1:0] lp
);

  logic [1:0] meta;

  // NOTE: non-blocking assignments make both flops sample the old value on the same edge, giving a true 2-stage chain.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      meta <= 2'b11;
      lp   <= 2'b11;
    end else begin
      meta <= {lp_p, lp_n};
      lp   <= meta;
    end
  end

endmodule

// File: rtl/dsi_lane_rx.sv
// DSI D-PHY data lane receiver: LP start-of-transmission detection, bit-aligned HS sync hunt,
// LSB-first byte deserialization and end-of-transmission detection on return to LP-11.
module dsi_lane_rx
  import dsi_rx_pkg::*;
#(
  parameter int         T_LPX_MIN    = 3,
  parameter int         T_PREP_MIN   = 3,
  parameter int         SYNC_TIMEOUT = 64,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       lines_enable,
  input  logic       serial_hs_input,
  input  logic       LP_p_input,
  input  logic       LP_n_input,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       sot_detected,
  output logic       eot_detected,
  output logic       active,
  output logic       err_sot,
  output logic       err_lp
);

  localparam int CNT_W = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LPX_MIN_C   = CNT_W'(T_LPX_MIN);
  localparam logic [CNT_W-1:0] PREP_MIN_C  = CNT_W'(T_PREP_MIN);
  localparam logic [CNT_W-1:0] HUNT_LAST_C = CNT_W'(SYNC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic [1:0]       lp;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       sr_q, sr_d, sr_next;
  logic [7:0]       data_d;
  logic             valid_d, sot_d, eot_d, err_sot_d, err_lp_d;

  dsi_lp_sync u_lp_sync (
    .clk_sys (clk_sys),
    .rst     (rst),
    .lp_p    (LP_p_input),
    .lp_n    (LP_n_input),
    .lp      (lp)
  );

  assign sr_next = {serial_hs_input, sr_q[7:1]};
  assign active  = (state_q != DISABLED) && (state_q != STOP);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    data_d    = out_data;
    valid_d   = 1'b0;
    sot_d     = 1'b0;
    eot_d     = 1'b0;
    err_sot_d = 1'b0;
    err_lp_d  = 1'b0;

    if (state_q != DISABLED && !lines_enable) begin
      state_d   = DISABLED;
      cnt_d     = '0;
      bit_cnt_d = '0;
      sr_d      = '0;
      data_d    = '0;
    end else begin
      case (state_q)
        DISABLED: if (lines_enable && lp == LP_11) state_d = STOP;

        STOP: begin
          case (lp)
            LP_01: begin
              state_d = HS_RQST;
              cnt_d   = CNT_ONE;
            end
            LP_11: ;
            default: begin
              err_lp_d = 1'b1;
              state_d  = ERROR;
            end
          endcase
        end

        HS_RQST: begin
          case (lp)
            LP_01: if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            LP_00: begin
              if (cnt_q >= LPX_MIN_C) begin
                state_d = HS_PREP;
                cnt_d   = CNT_ONE;
              end else begin
                err_lp_d = 1'b1;
                state_d  = ERROR;
              end
            end
            LP_11: state_d = STOP;
            default: begin
              err_lp_d = 1'b1;
              state_d  = ERROR;
            end
          endcase
        end

        HS_PREP: begin
          if (lp != LP_00) begin
            err_lp_d = 1'b1;
            state_d  = ERROR;
          end else if (cnt_q >= PREP_MIN_C) begin
            state_d = HS_SYNC;
            cnt_d   = '0;
            sr_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        HS_SYNC: begin
          sr_d  = sr_next;
          cnt_d = cnt_q + CNT_ONE;
          // Line activity outranks a sync match landing in the same cycle.
          if (lp != LP_00) begin
            err_sot_d = 1'b1;
            state_d   = ERROR;
          end else if (sr_next == SYNC_BYTE) begin
            state_d   = HS_DATA;
            bit_cnt_d = '0;
            sot_d     = 1'b1;
          end else if (cnt_q == HUNT_LAST_C) begin
            err_sot_d = 1'b1;
            state_d   = ERROR;
          end
        end

        HS_DATA: begin
          sr_d      = sr_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          // A byte completing on the EoT cycle is still delivered; partial bytes are dropped.
          if (bit_cnt_q == 3'd7 && (lp == LP_00 || lp == LP_11)) begin
            data_d  = sr_next;
            valid_d = 1'b1;
          end
          case (lp)
            LP_11: begin
              eot_d     = 1'b1;
              state_d   = STOP;
              bit_cnt_d = '0;
            end
            LP_01, LP_10: begin
              err_lp_d  = 1'b1;
              state_d   = ERROR;
              bit_cnt_d = '0;
            end
            default: ;
          endcase
        end

        ERROR: if (lp == LP_11) state_d = STOP;

        default: state_d = DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q      <= DISABLED;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      sot_detected <= 1'b0;
      eot_detected <= 1'b0;
      err_sot      <= 1'b0;
      err_lp       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sr_q         <= sr_d;
      out_data     <= data_d;
      out_valid    <= valid_d;
      sot_detected <= sot_d;
      eot_detected <= eot_d;
      err_sot      <= err_sot_d;
      err_lp       <= err_lp_d;
    end
  end

endmodule
